life_mode_sequencer: RTL and testbench
======================================

Name: life_mode_sequencer

Overview:
- Command-driven controller for the shift-register system memory in the Conway datapath.
- Generates the mutually exclusive LOAD_MODE / RUN_MODE / OUTPUT_MODE strobes that memory consumes.
- Counts serial bits for load and dump, and counts generations for run.
- Sits between the external command/serial interface and the memory; owns all mode sequencing.

Parameters:
- DATA_SIZE, 64, grid bits held in memory (bits per load/dump).
- GEN_WIDTH, 16, width of generation-count field.
- STEP_WAIT, 0, idle cycles inserted after each RUN_MODE pulse (grid calculator settle).

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- CMD_VALID  input  1  command present.
- CMD_READY  output  1  command accepted when CMD_VALID & CMD_READY.
- CMD_OP  input  2  00 NOP, 01 LOAD, 10 RUN, 11 DUMP.
- CMD_GENS  input  GEN_WIDTH  generations for RUN; ignored otherwise.
- SERIAL_IN_VALID  input  1  external serial bit present this cycle.
- LOAD_MODE  output  1  to memory: shift in SERIAL_IN.
- RUN_MODE  output  1  to memory: capture grid result.
- OUTPUT_MODE  output  1  to memory: shift out one bit.
- SERIAL_OUT_VALID  output  1  memory SERIAL_OUT holds a valid bit this cycle.
- BUSY  output  1  state != IDLE.
- DONE  output  1  one-cycle pulse at command completion.

Behaviour:
- States: IDLE, LOAD, RUN, RUN_WAIT, DUMP, FINISH.
- Reset (async, any state, mid-operation included): state IDLE; bit/gen/wait counters 0; SERIAL_OUT_VALID 0; DONE 0. Mode outputs decode to 0.
- CMD_READY = (state==IDLE); combinational. Commands offered while BUSY are not accepted; the requester holds them.
- Accept in cycle t → new state in t+1. NOP accept: state stays IDLE, no DONE.
- LOAD:
  - LOAD_MODE = (state==LOAD) & SERIAL_IN_VALID, combinational, same cycle as the bit.
  - Bit counter increments per asserted LOAD_MODE.
  - The cycle of the DATA_SIZE-th bit → FINISH. Gaps in SERIAL_IN_VALID stall without timeout.
- RUN:
  - CMD_GENS==0 → FINISH directly, no RUN_MODE pulse.
  - Otherwise the gen counter loads CMD_GENS.
  - In RUN: RUN_MODE=1 for exactly one cycle and the counter decrements.
  - Next state: FINISH if the counter was 1. Otherwise RUN_WAIT if STEP_WAIT>0, else RUN again (back-to-back pulses).
  - RUN_WAIT lasts exactly STEP_WAIT cycles, then RUN.
- DUMP:
  - OUTPUT_MODE=1 for exactly DATA_SIZE consecutive cycles, then FINISH.
  - SERIAL_OUT_VALID is OUTPUT_MODE registered one cycle, matching memory's registered SERIAL_OUT. It is high DATA_SIZE cycles, starting one cycle after the first OUTPUT_MODE.
  - Dump is destructive to the output register (zeros shifted in). The input register is untouched.
- FINISH: DONE=1 for one cycle → IDLE. Earliest next accept is the cycle after FINISH.
- At most one of LOAD_MODE/RUN_MODE/OUTPUT_MODE is high in any cycle; all are 0 in IDLE/FINISH/RUN_WAIT.
- Bit counter width $clog2(DATA_SIZE+1); wait counter width $clog2(STEP_WAIT+1), minimum 1. Neither counter wraps; the gen counter never decrements below 0.

Optional Feature:
- Macro: LIFE_SEQ_ABORT_EN.
- Defined: adds input ABORT (1 bit).
  - ABORT high in LOAD/RUN/RUN_WAIT/DUMP → next state FINISH. DONE pulses and counters clear.
  - The mode output in the abort cycle is still driven per current state; the command is terminated from the next cycle.
  - ABORT in IDLE/FINISH is ignored. ABORT has priority over command completion in the same cycle; there is still a single DONE pulse.
- Undefined: no ABORT port; commands always run to completion.

Decomposition:
- Package life_seq_pkg:
  - state enum (IDLE, LOAD, RUN, RUN_WAIT, DUMP, FINISH);
  - CMD_OP localparams OP_NOP/OP_LOAD/OP_RUN/OP_DUMP.
- Sub-module life_seq_counter: parameterised-width loadable down-counter with load, decrement and zero flag. Instantiated three times, for bits, gens and wait.

Test Plan (DATA_SIZE=64):
- Reset mid-DUMP (after 10 OUTPUT_MODE cycles) → all outputs 0 immediately; CMD_READY=1 after release; a new LOAD takes full 64 bits.
- LOAD with SERIAL_IN_VALID toggling 1,0,1,… → exactly 64 LOAD_MODE pulses over 127 cycles; DONE one cycle after the 64th bit.
- RUN CMD_GENS=3, STEP_WAIT=0 → RUN_MODE high 3 consecutive cycles, then DONE; CMD_GENS=0 → DONE 2 cycles after accept, no RUN_MODE.
- RUN CMD_GENS=2, STEP_WAIT=2 → RUN_MODE pattern 1,0,0,1, then DONE.
- DUMP → OUTPUT_MODE 64 cycles; SERIAL_OUT_VALID 64 cycles offset +1; memory serial stream equals previously loaded pattern 0xDEADBEEF_01234567 MSB first.
- CMD_VALID held during BUSY → CMD_READY=0, command accepted in first IDLE cycle; with LIFE_SEQ_ABORT_EN, ABORT at LOAD bit 5 → DONE next cycle, only 5 LOAD_MODE pulses.

Source files
------------

// File: rtl/life_seq_pkg.sv
// life_seq_pkg
//   Shared definitions for life_mode_sequencer: FSM state encoding and the
//   CMD_OP opcode values.
package life_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    RUN      = 3'd2,
    RUN_WAIT = 3'd3,
    DUMP     = 3'd4,
    FINISH   = 3'd5
  } life_seq_state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_DUMP = 2'b11;

endpackage

// File: rtl/life_seq_counter.sv
// life_seq_counter
//   Loadable down-counter with a zero flag. It saturates at zero and never
//   wraps. A load takes priority over a decrement.
// Ports:
//   CLK        rising-edge clock
//   RESET      asynchronous active-high reset, clears count
//   load       load load_value this cycle
//   load_value value to load
//   dec        decrement by one (ignored when count is zero)
//   count      current count
//   zero       count == 0
module life_seq_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/life_mode_sequencer.sv
// life_mode_sequencer
//   Command-driven controller for the Conway shift-register memory. It
//   accepts LOAD / RUN / DUMP commands and generates the mutually exclusive
//   LOAD_MODE / RUN_MODE / OUTPUT_MODE strobes. It counts serial bits for
//   load and dump and counts generations for run.
// Optional feature: define LIFE_SEQ_ABORT_EN to add the ABORT input, which
//   terminates an active command through FINISH.
// Ports:
//   CLK, RESET        clock; asynchronous active-high reset
//   CMD_VALID/READY   command handshake; READY is high only in IDLE
//   CMD_OP            00 NOP, 01 LOAD, 10 RUN, 11 DUMP
//   CMD_GENS          generation count for RUN
//   SERIAL_IN_VALID   external serial bit present this cycle
//   LOAD_MODE         memory shifts in SERIAL_IN
//   RUN_MODE          memory captures the grid result
//   OUTPUT_MODE       memory shifts out one bit
//   SERIAL_OUT_VALID  OUTPUT_MODE delayed one cycle (memory output is registered)
//   BUSY              state != IDLE
//   DONE              one-cycle pulse in FINISH
//   ABORT             (LIFE_SEQ_ABORT_EN only) terminate the current command
module life_mode_sequencer
  import life_seq_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 64,
  parameter int unsigned GEN_WIDTH = 16,
  parameter int unsigned STEP_WAIT = 0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  input  logic [1:0]           CMD_OP,
  input  logic [GEN_WIDTH-1:0] CMD_GENS,
  input  logic                 SERIAL_IN_VALID,
`ifdef LIFE_SEQ_ABORT_EN
  input  logic                 ABORT,
`endif
  output logic                 LOAD_MODE,
  output logic                 RUN_MODE,
  output logic                 OUTPUT_MODE,
  output logic                 SERIAL_OUT_VALID,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int unsigned BIT_W  = $clog2(DATA_SIZE + 1);
  localparam int unsigned WAIT_W = (STEP_WAIT > 0) ? $clog2(STEP_WAIT + 1) : 1;
  localparam logic [BIT_W-1:0]  BIT_LOAD  = BIT_W'(DATA_SIZE);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(STEP_WAIT);

  life_seq_state_t state, state_nxt;

  logic                 abort_req;
  logic                 bit_load, bit_dec, bit_zero;
  logic [BIT_W-1:0]     bit_val, bit_cnt;
  logic                 gen_load, gen_dec, gen_zero;
  logic [GEN_WIDTH-1:0] gen_val, gen_cnt;
  logic                 wait_load, wait_dec, wait_zero;
  logic [WAIT_W-1:0]    wait_val, wait_cnt;
  logic                 sov_q;

`ifdef LIFE_SEQ_ABORT_EN
  assign abort_req = ABORT;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      sov_q <= 1'b0;
    end else begin
      state <= state_nxt;
      sov_q <= OUTPUT_MODE;
    end
  end

  always_comb begin
    state_nxt = state;
    bit_load  = 1'b0;
    bit_val   = '0;
    bit_dec   = 1'b0;
    gen_load  = 1'b0;
    gen_val   = '0;
    gen_dec   = 1'b0;
    wait_load = 1'b0;
    wait_val  = '0;
    wait_dec  = 1'b0;
    case (state)
      IDLE: begin
        if (CMD_VALID) begin
          case (CMD_OP)
            OP_LOAD: begin
              state_nxt = LOAD;
              bit_load  = 1'b1;
              bit_val   = BIT_LOAD;
            end
            OP_RUN: begin
              // A zero generation count still passes through RUN, which
              // sees the zero flag and goes straight to FINISH without a pulse.
              state_nxt = RUN;
              gen_load  = 1'b1;
              gen_val   = CMD_GENS;
            end
            OP_DUMP: begin
              state_nxt = DUMP;
              bit_load  = 1'b1;
              bit_val   = BIT_LOAD;
            end
            default: ;
          endcase
        end
      end
      LOAD: begin
        if (SERIAL_IN_VALID) begin
          bit_dec = 1'b1;
          if (bit_cnt == BIT_W'(1) || bit_zero) state_nxt = FINISH;
        end
      end
      RUN: begin
        if (gen_zero) begin
          state_nxt = FINISH;
        end else begin
          gen_dec = 1'b1;
          if (gen_cnt == GEN_WIDTH'(1)) begin
            state_nxt = FINISH;
          end else if (STEP_WAIT > 0) begin
            state_nxt = RUN_WAIT;
            wait_load = 1'b1;
            wait_val  = WAIT_LOAD;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      RUN_WAIT: begin
        wait_dec = 1'b1;
        if (wait_cnt == WAIT_W'(1) || wait_zero) state_nxt = RUN;
      end
      DUMP: begin
        bit_dec = 1'b1;
        if (bit_cnt == BIT_W'(1) || bit_zero) state_nxt = FINISH;
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Abort overrides any completion decision made above, so the command
    // still produces exactly one FINISH/DONE.
    if (abort_req && (state == LOAD || state == RUN ||
                      state == RUN_WAIT || state == DUMP)) begin
      state_nxt = FINISH;
      bit_load  = 1'b1;
      bit_val   = '0;
      gen_load  = 1'b1;
      gen_val   = '0;
      wait_load = 1'b1;
      wait_val  = '0;
    end
  end

  life_seq_counter #(.WIDTH(BIT_W)) u_bit_cnt (
    .CLK        (CLK),
    .RESET      (RESET),
    .load       (bit_load),
    .load_value (bit_val),
    .dec        (bit_dec),
    .count      (bit_cnt),
    .zero       (bit_zero)
  );

  life_seq_counter #(.WIDTH(GEN_WIDTH)) u_gen_cnt (
    .CLK        (CLK),
    .RESET      (RESET),
    .load       (gen_load),
    .load_value (gen_val),
    .dec        (gen_dec),
    .count      (gen_cnt),
    .zero       (gen_zero)
  );

  life_seq_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .CLK        (CLK),
    .RESET      (RESET),
    .load       (wait_load),
    .load_value (wait_val),
    .dec        (wait_dec),
    .count      (wait_cnt),
    .zero       (wait_zero)
  );

  assign CMD_READY        = (state == IDLE);
  assign BUSY             = (state != IDLE);
  assign DONE             = (state == FINISH);
  assign LOAD_MODE        = (state == LOAD) && SERIAL_IN_VALID;
  assign RUN_MODE         = (state == RUN) && !gen_zero;
  assign OUTPUT_MODE      = (state == DUMP);
  assign SERIAL_OUT_VALID = sov_q;

endmodule

// File: tb/tb_life_mode_sequencer.sv
// tb_life_mode_sequencer
//   Directed plus randomized bench for life_mode_sequencer. Two instances
//   share inputs except CMD_VALID: dut0 uses STEP_WAIT=0 and dut2 uses
//   STEP_WAIT=2. A simple shift-register memory is attached to dut0 so the
//   serial dump stream can be compared against the pattern that was loaded.
//   Define LIFE_SEQ_ABORT_EN to also exercise ABORT.
module tb_life_mode_sequencer;
  import life_seq_pkg::*;

  localparam int DS = 64;

  logic        CLK, RESET, cv0, cv2, siv, sin;
  logic [1:0]  op;
  logic [15:0] gens;
  logic        rdy0, lm0, rm0, om0, sov0, busy0, done0;
  logic        rdy2, lm2, rm2, om2, sov2, busy2, done2;
  logic [6:0]  obs0, obs2;
  logic [63:0] mem, exp_mem;
  logic        sout;
  int          checks = 0;
  int          failures = 0;
`ifdef LIFE_SEQ_ABORT_EN
  logic        ab0, ab2;
`endif

  // Packed as {READY, BUSY, DONE, SOV, OUTPUT_MODE, RUN_MODE, LOAD_MODE}
  assign obs0 = {rdy0, busy0, done0, sov0, om0, rm0, lm0};
  assign obs2 = {rdy2, busy2, done2, sov2, om2, rm2, lm2};

  life_mode_sequencer #(.DATA_SIZE(DS), .GEN_WIDTH(16), .STEP_WAIT(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .CMD_VALID(cv0), .CMD_READY(rdy0),
    .CMD_OP(op), .CMD_GENS(gens), .SERIAL_IN_VALID(siv),
`ifdef LIFE_SEQ_ABORT_EN
    .ABORT(ab0),
`endif
    .LOAD_MODE(lm0), .RUN_MODE(rm0), .OUTPUT_MODE(om0),
    .SERIAL_OUT_VALID(sov0), .BUSY(busy0), .DONE(done0)
  );

  life_mode_sequencer #(.DATA_SIZE(DS), .GEN_WIDTH(16), .STEP_WAIT(2)) dut2 (
    .CLK(CLK), .RESET(RESET), .CMD_VALID(cv2), .CMD_READY(rdy2),
    .CMD_OP(op), .CMD_GENS(gens), .SERIAL_IN_VALID(siv),
`ifdef LIFE_SEQ_ABORT_EN
    .ABORT(ab2),
`endif
    .LOAD_MODE(lm2), .RUN_MODE(rm2), .OUTPUT_MODE(om2),
    .SERIAL_OUT_VALID(sov2), .BUSY(busy2), .DONE(done2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory stand-in for dut0: one shift register, MSB shifted out first,
  // zeros shifted in on dump, serial output registered.
  always @(posedge CLK) begin
    if (om0) begin
      sout <= mem[DS-1];
      mem  <= {mem[DS-2:0], 1'b0};
    end else if (lm0) begin
      mem  <= {mem[DS-2:0], sin};
    end
  end

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Expected outputs c cycles after a RUN accept (c=0 is the accept cycle).
  function automatic logic [6:0] exp_run(input int g, input int w, input int c);
    int dc;
    bit busy, dn, rm;
    dc   = (g == 0) ? 2 : (g - 1) * (w + 1) + 2;
    busy = (c >= 1) && (c <= dc);
    dn   = (c == dc);
    rm   = (g > 0) && (c >= 1) && (c < dc) && (((c - 1) % (w + 1)) == 0);
    return {!busy, busy, dn, 1'b0, 1'b0, rm, 1'b0};
  endfunction

  function automatic logic [6:0] exp_dump(input int c);
    bit busy;
    busy = (c >= 1) && (c <= DS + 1);
    return {!busy, busy, c == DS + 1, (c >= 2) && (c <= DS + 1),
            (c >= 1) && (c <= DS), 1'b0, 1'b0};
  endfunction

  task automatic do_cmd(input int sel, input logic [1:0] cop, input int g,
                        input logic [63:0] pat, input int vmode, input int rst_at,
                        input int abort_bit, input string name);
    int c, sent, done_c, w, n_lm, n_rm, n_done;
    bit sv, ab, busy_e, done_e, lm_e;
    logic [6:0]  e, o;
    logic [63:0] stream, snap;
    w = (sel == 2) ? 2 : 0;
    sent = 0; n_lm = 0; n_rm = 0; n_done = 0;
    stream = '0;
    snap = exp_mem;
    if (cop == OP_RUN)       done_c = (g == 0) ? 2 : (g - 1) * (w + 1) + 2;
    else if (cop == OP_DUMP) done_c = DS + 1;
    else if (cop == OP_NOP)  done_c = 0;
    else                     done_c = -1;
    for (c = 0; c <= 600; c++) begin
      @(negedge CLK);
      if (sel == 0) cv0 = (c == 0); else cv2 = (c == 0);
      op   = cop;
      gens = 16'(g);
      case (vmode)
        0:       sv = 1'($urandom_range(0, 1));
        1:       sv = ((c % 2) == 1);
        default: sv = 1'b1;
      endcase
      siv = sv;
      sin = (sent < DS) ? pat[DS-1-sent] : 1'b0;
      ab  = 1'b0;
`ifdef LIFE_SEQ_ABORT_EN
      ab  = (cop == OP_LOAD) && (abort_bit > 0) && (c >= 1) && (done_c < 0) &&
            sv && (sent == abort_bit - 1);
      ab0 = ab && (sel == 0);
      ab2 = ab && (sel == 2);
`endif
      if (rst_at > 0 && c == rst_at) begin
        RESET = 1'b1;
        #1;
        o = (sel == 0) ? obs0 : obs2;
        check({name, " outputs in reset"}, 64'(o[5:0]), 64'(0));
        RESET = 1'b0;
        #1;
        o = (sel == 0) ? obs0 : obs2;
        check({name, " ready after reset"}, 64'(o[6]), 64'(1));
        return;
      end
      #1;
      o = (sel == 0) ? obs0 : obs2;
      if (cop == OP_RUN) begin
        e = exp_run(g, w, c);
      end else if (cop == OP_DUMP) begin
        e = exp_dump(c);
      end else begin
        busy_e = (c >= 1) && (done_c < 0 || c <= done_c);
        done_e = (c >= 1) && (c == done_c);
        lm_e   = (cop == OP_LOAD) && busy_e && !done_e && sv;
        e = {!busy_e, busy_e, done_e, 3'b000, lm_e};
      end
      check($sformatf("%s c%0d", name, c), 64'(o), 64'(e));
      n_lm   += int'(o[0]);
      n_rm   += int'(o[1]);
      n_done += int'(o[4]);
      if (sel == 0 && e[3]) stream[DS-1-(c-2)] = sout;
      if (sel == 0 && e[2]) exp_mem = exp_mem << 1;
      if (e[0]) begin
        if (sel == 0) exp_mem = {exp_mem[DS-2:0], pat[DS-1-sent]};
        sent++;
        if (sent == DS) done_c = c + 1;
      end
      if (ab) done_c = c + 1;
      if (done_c >= 0 && c == done_c + 1) break;
    end
`ifdef LIFE_SEQ_ABORT_EN
    ab0 = 1'b0;
    ab2 = 1'b0;
`endif
    check({name, " completed in time"}, 64'(c <= 600), 64'(1));
    check({name, " DONE pulses"}, 64'(n_done), 64'((cop == OP_NOP) ? 0 : 1));
    if (cop == OP_LOAD) check({name, " LOAD_MODE pulses"}, 64'(n_lm), 64'((abort_bit > 0) ? abort_bit : DS));
    if (cop == OP_RUN)  check({name, " RUN_MODE pulses"}, 64'(n_rm), 64'(g));
    if (cop == OP_DUMP && sel == 0) check({name, " serial stream"}, stream, snap);
  endtask

  initial begin
    logic [6:0] e;
    RESET = 1'b1; cv0 = 1'b0; cv2 = 1'b0; op = OP_NOP; gens = '0;
    siv = 1'b0; sin = 1'b0; mem = '0; sout = 1'b0; exp_mem = '0;
`ifdef LIFE_SEQ_ABORT_EN
    ab0 = 1'b0; ab2 = 1'b0;
`endif
    #12;
    check("reset dut0", 64'(obs0), 64'(7'b1000000));
    check("reset dut2", 64'(obs2), 64'(7'b1000000));
    @(negedge CLK);
    RESET = 1'b0;

    do_cmd(0, OP_LOAD, 0, 64'hDEADBEEF_01234567, 1, 0, 0, "load_toggle");
    do_cmd(0, OP_DUMP, 0, '0, 0, 11, 0, "dump_reset");
    do_cmd(0, OP_LOAD, 0, 64'hDEADBEEF_01234567, 0, 0, 0, "load_after_reset");
    do_cmd(0, OP_DUMP, 0, '0, 0, 0, 0, "dump_full");
    do_cmd(0, OP_RUN, 3, '0, 0, 0, 0, "run3_w0");
    do_cmd(0, OP_RUN, 0, '0, 0, 0, 0, "run0_w0");
    do_cmd(2, OP_RUN, 2, '0, 0, 0, 0, "run2_w2");
    do_cmd(2, OP_RUN, 0, '0, 0, 0, 0, "run0_w2");
    do_cmd(0, OP_NOP, 0, '0, 0, 0, 0, "nop");

    // CMD_VALID held through a busy RUN: second copy accepted at first IDLE cycle
    for (int c = 0; c <= 8; c++) begin
      @(negedge CLK);
      cv0 = (c <= 4); op = OP_RUN; gens = 16'd2; siv = 1'($urandom_range(0, 1));
      #1;
      e = (c < 4) ? exp_run(2, 0, c) : exp_run(2, 0, c - 4);
      check($sformatf("hold c%0d", c), 64'(obs0), 64'(e));
    end
    cv0 = 1'b0;

`ifdef LIFE_SEQ_ABORT_EN
    do_cmd(0, OP_LOAD, 0, {$urandom, $urandom}, 0, 0, 5, "load_abort5");
`endif

    for (int i = 0; i < 16; i++) begin
      int s, rg;
      logic [1:0]  rop;
      logic [63:0] rp;
      s   = 2 * int'($urandom_range(0, 1));
      rop = 2'($urandom_range(0, 3));
      rg  = int'($urandom_range(0, 4));
      rp  = {$urandom, $urandom};
      do_cmd(s, rop, rg, rp, 0, 0, 0, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
